// File: rtl/jt900h_dump_seq_pkg.sv
// Shared constants for the register-dump serializer: FSM encoding and
// default frame framing values.
package jt900h_dump_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_CHK   = 3'd5
  } dump_st_e;

  localparam logic [7:0] DUMP_HEADER    = 8'hA5;
  localparam logic [7:0] DUMP_LAST_ADDR = 8'h51;

endpackage

// File: rtl/jt900h_dump_seq.sv
// Streams a register dump as HEADER, bytes 0..LAST_ADDR, then a checksum byte
// that zeroes the 8-bit sum of the whole frame.
module jt900h_dump_seq
  import jt900h_dump_seq_pkg::*;
#(
  parameter logic [7:0] LAST_ADDR = DUMP_LAST_ADDR,
  parameter logic [7:0] HEADER    = DUMP_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] dmp_addr,
  input  logic [7:0] dmp_din,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  dump_st_e   st;
  logic [7:0] addr;
  logic [7:0] sum;
  logic [7:0] sum_nxt;
  logic       xfer;

  assign dmp_addr = addr;
  assign xfer     = tx_valid & tx_ready;
  assign sum_nxt  = sum + tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      addr     <= 8'd0;
      sum      <= 8'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort wins over a transfer landing on the same edge
      if (abort && st != ST_IDLE) begin
        st       <= ST_IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: if (start && !abort) begin
            st       <= ST_HDR;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
          ST_HDR: if (xfer) begin
            st       <= ST_FETCH;
            addr     <= 8'd0;
            sum      <= HEADER;
            tx_valid <= 1'b0;
          end
          ST_FETCH: st <= ST_LOAD;
          // dmp_din now reflects the address presented during FETCH
          ST_LOAD: begin
            st       <= ST_SEND;
            tx_data  <= dmp_din;
            tx_valid <= 1'b1;
          end
          ST_SEND: if (xfer) begin
            sum <= sum_nxt;
            if (addr == LAST_ADDR) begin
              st      <= ST_CHK;
              tx_data <= ~sum_nxt + 8'd1;
            end else begin
              st       <= ST_FETCH;
              addr     <= addr + 8'd1;
              tx_valid <= 1'b0;
            end
          end
          ST_CHK: if (xfer) begin
            st       <= ST_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
          default: begin
            st       <= ST_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
